// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_unit_pkg
//  Brief    : Shared constants, FSM encoding and queue entry type for fetch.
//  Revision : 1.0
// ============================================================================
package pc_fetch_unit_pkg;

    localparam int                     c_DATA_SIZE        = 32;
    localparam logic [c_DATA_SIZE-1:0] c_DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [c_DATA_SIZE-1:0] c_NOP_INST         = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [c_DATA_SIZE-1:0] pc;
        logic [c_DATA_SIZE-1:0] inst;
    } fetch_entry_t;

    function automatic logic [c_DATA_SIZE-1:0] word_align(input logic [c_DATA_SIZE-1:0] addr);
        return {addr[c_DATA_SIZE-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Brief    : Synchronous FIFO of {pc, inst} entries with single-cycle flush.
//  Revision : 1.0
// ============================================================================
module fetch_queue
    import pc_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   i_push,
    input  fetch_entry_t           i_entry,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full,
    output fetch_entry_t           o_head
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    fetch_entry_t    r_mem [DEPTH];
    logic [c_AW-1:0] r_rdPtr;
    logic [c_AW-1:0] r_wrPtr;
    logic [c_CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wrPtr] <= i_entry;
        end
    end

    // Power-of-two depth lets both pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wrPtr <= r_wrPtr + c_AW'(1);
            end
            if (i_pop) begin
                r_rdPtr <= r_rdPtr + c_AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_CW'(DEPTH));
    assign o_head  = r_mem[r_rdPtr];

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_unit
//  Brief    : Fetch PC owner, imem req/gnt/rsp sequencer and IF/ID feed queue.
//  Revision : 1.0
// ============================================================================
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = c_DEFAULT_RESET_PC,
    parameter int          QUEUE_DEPTH = 2,
    parameter logic [31:0] PC_STEP     = 32'd4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        stall,
    input  logic        redirectValid,
    input  logic [31:0] redirectPc,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRspValid,
    input  logic [31:0] imemRspData,
    output logic        instValid,
    output logic [31:0] instData,
    output logic [31:0] instPc
);

    localparam int c_CW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_e    r_state;
    logic [31:0]     r_fetchPc;
    logic [31:0]     r_reqPc;
    fetch_entry_t    r_lastHead;

    logic            w_redirect;
    logic [31:0]     w_target;
    logic            w_req;
    logic            w_handshake;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic            w_full;
    logic [c_CW-1:0] w_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_pushEntry;

    // BOOT has nothing in flight, so a redirect there is simply dropped.
    assign w_redirect  = redirectValid && (r_state != ST_BOOT);
    assign w_target    = word_align(redirectPc);
    assign w_req       = (r_state == ST_REQ) && (w_count < c_CW'(QUEUE_DEPTH));
    assign w_handshake = w_req && imemGnt;
    assign w_pop       = !w_empty && !stall && !w_redirect;
    assign w_push      = (r_state == ST_WAIT) && imemRspValid && !w_redirect
                         && (!w_full || w_pop);
    assign w_pushEntry = '{pc: r_reqPc, inst: imemRspData};

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .resetN  (resetN),
        .i_push  (w_push),
        .i_entry (w_pushEntry),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_head  (w_head)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state   <= ST_BOOT;
            r_fetchPc <= RESET_PC;
            r_reqPc   <= RESET_PC;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_REQ;
                end
                ST_REQ: begin
                    if (w_handshake) begin
                        r_reqPc <= r_fetchPc;
                        if (w_redirect) begin
                            r_fetchPc <= w_target;
                            r_state   <= ST_DRAIN;
                        end else begin
                            r_fetchPc <= r_fetchPc + PC_STEP;
                            r_state   <= ST_WAIT;
                        end
                    end else if (w_redirect) begin
                        r_fetchPc <= w_target;
                    end
                end
                ST_WAIT: begin
                    if (w_redirect) begin
                        r_fetchPc <= w_target;
                        r_state   <= imemRspValid ? ST_REQ : ST_DRAIN;
                    end else if (imemRspValid) begin
                        r_state <= ST_REQ;
                    end
                end
                default: begin
                    // The owed response settles DRAIN even if a newer redirect lands with it.
                    if (w_redirect) begin
                        r_fetchPc <= w_target;
                    end
                    if (imemRspValid) begin
                        r_state <= ST_REQ;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_lastHead <= '{pc: RESET_PC, inst: c_NOP_INST};
        end else if (!w_empty) begin
            r_lastHead <= w_head;
        end
    end

    assign imemReq   = w_req;
    assign imemAddr  = r_fetchPc;
    assign instValid = !w_empty;
    assign instData  = w_empty ? r_lastHead.inst : w_head.inst;
    assign instPc    = w_empty ? r_lastHead.pc   : w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch_unit
//  Brief    : Scoreboard bench for pc_fetch_unit with a modelled instruction memory.
//  Revision : 1.0
// ============================================================================
module tb_pc_fetch_unit;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;

    logic        clk           = 1'b0;
    logic        resetN        = 1'b0;
    logic        stall         = 1'b0;
    logic        redirectValid = 1'b0;
    logic [31:0] redirectPc    = '0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt       = 1'b0;
    logic        imemRspValid  = 1'b0;
    logic [31:0] imemRspData   = '0;
    logic        instValid;
    logic [31:0] instData;
    logic [31:0] instPc;

    pc_fetch_unit #(
        .RESET_PC    (c_RESET_PC),
        .QUEUE_DEPTH (2),
        .PC_STEP     (32'd4)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .stall         (stall),
        .redirectValid (redirectValid),
        .redirectPc    (redirectPc),
        .imemReq       (imemReq),
        .imemAddr      (imemAddr),
        .imemGnt       (imemGnt),
        .imemRspValid  (imemRspValid),
        .imemRspData   (imemRspData),
        .instValid     (instValid),
        .instData      (instData),
        .instPc        (instPc)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pops   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_next = c_RESET_PC;
    logic [63:0] mon_e;

    bit          gnt_rand  = 1'b0;
    bit          gnt_block = 1'b0;
    int          lat_fixed = 1;
    bit          pend      = 1'b0;
    int          cd        = 0;
    logic [31:0] paddr     = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural expectation: after reset or a redirect, IF/ID sees consecutive words.
    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back({exp_next, mem_word(exp_next)});
            exp_next = exp_next + 32'd4;
        end
    endtask

    task automatic restart_stream(input logic [31:0] pc);
        exp_q.delete();
        exp_next = {pc[31:2], 2'b00};
        refill();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        refill();
    endtask

    task automatic do_reset();
        resetN        = 1'b0;
        stall         = 1'b0;
        redirectValid = 1'b0;
        restart_stream(c_RESET_PC);
        tick();
        tick();
        resetN = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redirectValid = 1'b1;
        redirectPc    = tgt;
        restart_stream(tgt);
        tick();
        redirectValid = 1'b0;
    endtask

    task automatic wait_valid(input int bound, input string name);
        for (int i = 0; i < bound && !instValid; i++) begin
            tick();
        end
        chk(name, {31'd0, instValid}, 32'd1);
    endtask

    // Instruction memory: in-order, one outstanding, latency fixed or random 1..3.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!resetN) begin
                pend         = 1'b0;
                imemGnt      = 1'b0;
                imemRspValid = 1'b0;
            end else begin
                if (pend && cd == 0) begin
                    imemRspValid = 1'b1;
                    imemRspData  = mem_word(paddr);
                    pend         = 1'b0;
                end else begin
                    imemRspValid = 1'b0;
                    imemRspData  = $urandom;
                    if (pend) cd--;
                end
                imemGnt = gnt_block ? 1'b0 : (gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1);
                if (imemReq && imemGnt) begin
                    pend  = 1'b1;
                    paddr = imemAddr;
                    cd    = (lat_fixed > 0 ? lat_fixed : int'($urandom_range(1, 3))) - 1;
                end
            end
        end
    end

    // Monitor: every accepted head entry must be the next expected {pc, inst}.
    initial begin
        forever begin
            @(negedge clk);
            if (resetN && instValid && !stall && !redirectValid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pop_underflow: got pc %h expected no entry", instPc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pop_pc", instPc, mon_e[63:32]);
                    chk("pop_data", instData, mon_e[31:0]);
                    n_pops++;
                end
            end
        end
    end

    initial begin
        restart_stream(c_RESET_PC);
        tick();
        tick();
        chk("rst_req", {31'd0, imemReq}, 32'd0);
        chk("rst_addr", imemAddr, c_RESET_PC);
        chk("rst_valid", {31'd0, instValid}, 32'd0);
        chk("rst_data", instData, c_NOP);
        chk("rst_pc", instPc, c_RESET_PC);

        // Streaming memory, 1-cycle response
        lat_fixed = 1;
        do_reset();
        chk("boot_req", {31'd0, imemReq}, 32'd0);
        tick();
        chk("first_req", {31'd0, imemReq}, 32'd1);
        chk("first_addr", imemAddr, 32'h0);
        tick();
        chk("wait_req", {31'd0, imemReq}, 32'd0);
        chk("wait_valid", {31'd0, instValid}, 32'd0);
        tick();
        chk("lat_valid", {31'd0, instValid}, 32'd1);
        chk("lat_pc", instPc, 32'h0);
        chk("lat_data", instData, mem_word(32'h0));
        chk("second_addr", imemAddr, 32'h4);
        tick();
        tick();
        chk("third_addr", imemAddr, 32'h8);

        // Stall until the queue fills
        stall = 1'b1;
        repeat (5) tick();
        chk("full_req", {31'd0, imemReq}, 32'd0);
        chk("full_valid", {31'd0, instValid}, 32'd1);
        chk("full_head", instPc, 32'h4);
        stall = 1'b0;
        repeat (20) tick();

        // Redirect from WAIT with the response still 3 cycles away
        lat_fixed = 4;
        do_reset();
        tick();
        tick();
        do_redirect(32'h0000_0100);
        chk("drain_flush", {31'd0, instValid}, 32'd0);
        chk("drain_req0", {31'd0, imemReq}, 32'd0);
        tick();
        chk("drain_req1", {31'd0, imemReq}, 32'd0);
        tick();
        chk("drain_req2", {31'd0, imemReq}, 32'd0);
        tick();
        lat_fixed = 1;
        chk("redir_req", {31'd0, imemReq}, 32'd1);
        chk("redir_addr", imemAddr, 32'h0000_0100);
        wait_valid(10, "redir_valid_timeout");
        chk("redir_pc", instPc, 32'h0000_0100);
        repeat (10) tick();

        // Redirect coinciding with the response (target misaligned)
        do_reset();
        tick();
        tick();
        do_redirect(32'h0000_0203);
        chk("coinc_req", {31'd0, imemReq}, 32'd1);
        chk("coinc_addr", imemAddr, 32'h0000_0200);
        chk("coinc_valid", {31'd0, instValid}, 32'd0);
        repeat (10) tick();

        // Grant withheld for 4 cycles
        do_reset();
        repeat (5) tick();
        gnt_block = 1'b1;
        chk("hold_addr0", imemAddr, 32'h8);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_req", {31'd0, imemReq}, 32'd1);
            chk("hold_addr", imemAddr, 32'h8);
        end
        gnt_block = 1'b0;
        tick();
        tick();
        chk("after_hold_req", {31'd0, imemReq}, 32'd1);
        chk("after_hold_addr", imemAddr, 32'hC);
        repeat (10) tick();

        // Address wrap
        do_reset();
        tick();
        do_redirect(32'hFFFF_FFFC);
        tick();
        chk("wrap_addr0", imemAddr, 32'hFFFF_FFFC);
        tick();
        tick();
        chk("wrap_addr1", imemAddr, 32'h0000_0000);
        repeat (10) tick();

        // Asynchronous reset in WAIT
        lat_fixed = 3;
        do_reset();
        tick();
        tick();
        resetN = 1'b0;
        #1;
        chk("async_req", {31'd0, imemReq}, 32'd0);
        chk("async_addr", imemAddr, c_RESET_PC);
        chk("async_valid", {31'd0, instValid}, 32'd0);
        chk("async_data", instData, c_NOP);
        chk("async_pc", instPc, c_RESET_PC);
        do_reset();
        tick();

        // Randomized traffic
        gnt_rand  = 1'b1;
        lat_fixed = 0;
        tick();
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                tick();
            end else if ($urandom_range(0, 39) == 0) begin
                do_redirect($urandom);
            end else begin
                tick();
            end
        end
        gnt_rand = 1'b0;
        stall    = 1'b0;
        repeat (20) tick();
        chk("progress", {31'd0, n_pops > 200}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
